// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serialising single-word requester transactions onto one memory bus.
// Define MEMARB_FIXED_PRIO_EN for fixed priority (lowest index wins, starvation possible).
module mem_bus_arbiter #(
    parameter int NREQ       = 8,
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        rdata,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, ACK} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [2:0]      cnt_q, cnt_d;

    logic            grant_vld;
    logic [IW-1:0]   grant_idx;

`ifdef MEMARB_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (req[i-1]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(i - 1);
            end
        end
    end
`else
    localparam int unsigned NR = NREQ;
    int unsigned   rr_idx;
    logic [IW-1:0] rr_sel;

    // Descending scan so the nearest requester after the last winner is the final assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        rr_sel    = '0;
        for (int unsigned k = NR; k > 0; k--) begin
            rr_idx = (32'(win_q) + k) % NR;
            rr_sel = rr_idx[IW-1:0];
            if (req[rr_sel]) begin
                grant_vld = 1'b1;
                grant_idx = rr_sel;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    win_d   = grant_idx;
                    we_d    = req_we[grant_idx];
                    addr_d  = req_addr[grant_idx*AW +: AW];
                    wdata_d = req_wdata[grant_idx*DW +: DW];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // First ISSUE cycle raises the strobe; busy is only honoured once it is up.
                if (!rd_q && !wr_q) begin
                    rd_d = !we_q;
                    wr_d = we_q;
                end else if (!mem_busy) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (we_q) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT_RD;
                        cnt_d   = 3'(RD_LATENCY - 1);
                    end
                end
            end
            WAIT_RD: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = mem_rdata;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            win_q   <= IW'(NREQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == ACK) ack[win_q] = 1'b1;
    end

    assign rdata     = rdata_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
